// File: rtl/cfc_pkg.sv
// Shared definitions for the cfc MAC bank and its sequencer: command codes, lane count, FSM states.
// No logic of its own; imported by the sequencer, the issuer and the cfc responder.
package cfc_pkg;

  localparam int CFC_LANES = 4;

  typedef logic [1:0] cfc_op_t;

  localparam cfc_op_t CFC_NOP   = 2'd0;
  localparam cfc_op_t CFC_CLEAR = 2'd1;
  localparam cfc_op_t CFC_MAC   = 2'd2;
  localparam cfc_op_t CFC_GET   = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLR_ISSUE,
    ST_CLR_WAIT,
    ST_FETCH,
    ST_MAC_ISSUE,
    ST_MAC_WAIT,
    ST_GET_ISSUE,
    ST_GET_WAIT,
    ST_OUT,
    ST_ABORT
  } seq_state_t;

  function automatic logic is_wait(seq_state_t s);
    return (s == ST_CLR_WAIT) || (s == ST_MAC_WAIT) || (s == ST_GET_WAIT);
  endfunction

endpackage

// File: rtl/cfc_sequencer_if.sv
// Bundle of the sequencer's pixel stream, cfc command port, result port and status flags.
// master = sequencer side, slave = front end / cfc / downstream side.
interface cfc_sequencer_if;
  import cfc_pkg::*;

  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_pixel;
  logic signed [7:0] in_weight;

  cfc_op_t           op_code;
  logic [1:0]        index;
  logic [7:0]        value_a;
  logic signed [7:0] value_b;
  logic [31:0]       data_out;
  logic              done;

  logic [31:0]       result;
  logic              result_valid;
  logic              result_ready;

  logic              busy;
  logic              error;

  modport master (
    input  start, in_valid, in_pixel, in_weight, data_out, done, result_ready,
    output in_ready, op_code, index, value_a, value_b, result, result_valid, busy, error
  );

  modport slave (
    output start, in_valid, in_pixel, in_weight, data_out, done, result_ready,
    input  in_ready, op_code, index, value_a, value_b, result, result_valid, busy, error
  );

endinterface

// File: rtl/cfc_cmd_issuer.sv
// Drives a cfc command for the single ISSUE cycle, then qualifies done (never on the first WAIT
// cycle, which may carry a stale done) and flags timeout after TIMEOUT WAIT cycles without one.
module cfc_cmd_issuer
  import cfc_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    issue,
  input  cfc_op_t issue_op,
  input  logic    waiting,
  input  logic    done,
  output cfc_op_t op_code,
  output logic    complete,
  output logic    timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;
  logic          last_wait;

  assign last_wait = (wait_cnt == CW'(TIMEOUT - 1));

  // wait_cnt is the index of the current WAIT cycle; the ISSUE cycle always precedes a WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (issue) begin
      wait_cnt <= '0;
    end else if (waiting && !last_wait) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign op_code  = issue ? issue_op : CFC_NOP;
  assign complete = waiting && (wait_cnt != '0) && done;
  assign timeout  = waiting && last_wait && !complete;

endmodule

// File: rtl/cfc_sequencer.sv
// Runs one cfc job per start: CLEAR, TAPS*4 MACs round-robin over the lanes, GET, then presents
// the 32-bit lane result on a valid/ready port; pairs are only taken while fetching.
module cfc_sequencer
  import cfc_pkg::*;
#(
  parameter int TAPS    = 9,
  parameter int TIMEOUT = 16
) (
  input  logic     clk,
  input  logic     rst,
  cfc_sequencer_if.master bus
);

  localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;

  seq_state_t        state, state_n;
  logic [1:0]        lane;
  logic [TW-1:0]     tap;
  logic [1:0]        index_q;
  logic [7:0]        value_a_q;
  logic signed [7:0] value_b_q;
  logic [31:0]       result_q;
  logic              error_q;

  logic              issue, waiting, complete, timeout;
  cfc_op_t           issue_op;
  logic              start_ok, pair_hs, last_pair;

  assign start_ok  = (state == ST_IDLE) && bus.start;
  assign pair_hs   = (state == ST_FETCH) && bus.in_valid;
  assign last_pair = (lane == 2'(CFC_LANES - 1)) && (tap == TW'(TAPS - 1));
  assign waiting   = is_wait(state);

  cfc_cmd_issuer #(
    .TIMEOUT (TIMEOUT)
  ) u_issuer (
    .clk      (clk),
    .rst      (rst),
    .issue    (issue),
    .issue_op (issue_op),
    .waiting  (waiting),
    .done     (bus.done),
    .op_code  (bus.op_code),
    .complete (complete),
    .timeout  (timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    issue    = 1'b0;
    issue_op = CFC_NOP;
    case (state)
      ST_IDLE: begin
        if (bus.start) state_n = ST_CLR_ISSUE;
      end
      ST_CLR_ISSUE: begin
        issue    = 1'b1;
        issue_op = CFC_CLEAR;
        state_n  = ST_CLR_WAIT;
      end
      ST_CLR_WAIT: begin
        if (complete)     state_n = ST_FETCH;
        else if (timeout) state_n = ST_ABORT;
      end
      ST_FETCH: begin
        if (bus.in_valid) state_n = ST_MAC_ISSUE;
      end
      ST_MAC_ISSUE: begin
        issue    = 1'b1;
        issue_op = CFC_MAC;
        state_n  = ST_MAC_WAIT;
      end
      ST_MAC_WAIT: begin
        if (complete)     state_n = last_pair ? ST_GET_ISSUE : ST_FETCH;
        else if (timeout) state_n = ST_ABORT;
      end
      ST_GET_ISSUE: begin
        issue    = 1'b1;
        issue_op = CFC_GET;
        state_n  = ST_GET_WAIT;
      end
      ST_GET_WAIT: begin
        if (complete)     state_n = ST_OUT;
        else if (timeout) state_n = ST_ABORT;
      end
      ST_OUT: begin
        if (bus.result_ready) state_n = ST_IDLE;
      end
      ST_ABORT: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Stream is tap-major: lane steps every MAC, tap steps when lane wraps 3 -> 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane <= '0;
      tap  <= '0;
    end else if (start_ok) begin
      lane <= '0;
      tap  <= '0;
    end else if ((state == ST_MAC_WAIT) && complete) begin
      lane <= lane + 2'd1;
      if (lane == 2'(CFC_LANES - 1)) tap <= tap + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index_q   <= '0;
      value_a_q <= '0;
      value_b_q <= '0;
    end else if (pair_hs) begin
      index_q   <= lane;
      value_a_q <= bus.in_pixel;
      value_b_q <= bus.in_weight;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
    end else if ((state == ST_GET_WAIT) && complete) begin
      result_q <= bus.data_out;
    end
  end

  // Sticky until the next accepted start, so a host can read it after busy drops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error_q <= 1'b0;
    end else if (start_ok) begin
      error_q <= 1'b0;
    end else if (timeout) begin
      error_q <= 1'b1;
    end
  end

  assign bus.in_ready     = (state == ST_FETCH);
  assign bus.result_valid = (state == ST_OUT);
  assign bus.busy         = (state != ST_IDLE);
  assign bus.index        = index_q;
  assign bus.value_a      = value_a_q;
  assign bus.value_b      = value_b_q;
  assign bus.result       = result_q;
  assign bus.error        = error_q;

endmodule

// File: tb/tb_cfc_sequencer.sv
// Two sequencers (TAPS=1 and TAPS=2) each driving a behavioural cfc; one is selected per job and
// its result is compared with lane sums computed directly from the pair list.
module tb_cfc_sequencer;
  import cfc_pkg::*;

  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start = 1'b0, in_valid = 1'b0, result_ready = 1'b0, hang = 1'b0;
  logic [7:0] in_pixel = 8'h00, in_weight = 8'h00;
  logic       sel = 1'b0;

  logic        rdy_v [2], rv_v [2], busy_v [2], err_v [2];
  logic [1:0]  op_v [2], idx_v [2];
  logic [7:0]  a_v [2], b_v [2];
  logic [31:0] res_v [2];

  for (genvar g = 0; g < 2; g++) begin : gi
    cfc_sequencer_if bus ();
    logic [7:0] acc [4] = '{default: 8'h00};
    logic       done_r = 1'b0;
    logic       pend = 1'b0;
    cfc_op_t    last_op = CFC_NOP;

    cfc_sequencer #(.TAPS(g + 1), .TIMEOUT(TIMEOUT)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    assign bus.start        = start && (sel == 1'(g));
    assign bus.in_valid     = in_valid && (sel == 1'(g));
    assign bus.in_pixel     = in_pixel;
    assign bus.in_weight    = in_weight;
    assign bus.result_ready = result_ready && (sel == 1'(g));
    assign bus.data_out     = {acc[3], acc[2], acc[1], acc[0]};
    assign bus.done         = done_r;

    // cfc model: done is a level that turns valid one cycle after the command cycle
    always @(posedge clk) begin
      if (bus.op_code != CFC_NOP) begin
        pend    <= 1'b1;
        last_op <= bus.op_code;
        case (bus.op_code)
          CFC_CLEAR: for (int i = 0; i < 4; i++) acc[i] <= 8'h00;
          CFC_MAC:   acc[bus.index] <= 8'(int'(acc[bus.index]) + int'(bus.value_a) * int'(bus.value_b));
          default: ;
        endcase
      end else if (pend) begin
        pend   <= 1'b0;
        done_r <= !(hang && (last_op == CFC_GET));
      end
    end

    assign rdy_v[g]  = bus.in_ready;
    assign rv_v[g]   = bus.result_valid;
    assign busy_v[g] = bus.busy;
    assign err_v[g]  = bus.error;
    assign op_v[g]   = bus.op_code;
    assign idx_v[g]  = bus.index;
    assign a_v[g]    = bus.value_a;
    assign b_v[g]    = bus.value_b;
    assign res_v[g]  = bus.result;
  end

  logic        rdy_s, rv_s, busy_s, err_s;
  logic [1:0]  op_s;
  logic [31:0] res_s;
  assign rdy_s  = rdy_v[sel];
  assign rv_s   = rv_v[sel];
  assign busy_s = busy_v[sel];
  assign err_s  = err_v[sel];
  assign op_s   = op_v[sel];
  assign res_s  = res_v[sel];

  int cyc = 0, hs = 0, macs = 0, viol = 0, rvs = 0;
  always @(negedge clk) begin
    if (busy_s && !rv_s) cyc++;
    if (in_valid && rdy_s) hs++;
    if (op_s == CFC_MAC) macs++;
    if (rdy_s && ((op_s != CFC_NOP) || rv_s)) viol++;
    if (rv_s) rvs++;
  end

  int total = 0, bad = 0;
  int cyc_base = 0;
  logic [7:0] pix_q [$];
  logic [7:0] wt_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Lane k mod 4 accumulates pixel*weight, truncated to 8 bits
  function automatic logic [31:0] ref_result(int taps);
    logic [7:0] s [4];
    for (int l = 0; l < 4; l++) s[l] = 8'h00;
    for (int k = 0; k < 4 * taps; k++)
      s[k % 4] = 8'(int'(s[k % 4]) + int'(pix_q[k]) * int'($signed(wt_q[k])));
    return {s[3], s[2], s[1], s[0]};
  endfunction

  task automatic fill_rand(input int n);
    pix_q.delete();
    wt_q.delete();
    for (int k = 0; k < n; k++) begin
      pix_q.push_back(8'($urandom_range(0, 255)));
      wt_q.push_back(8'($urandom_range(0, 255)));
    end
  endtask

  task automatic start_job();
    cyc_base = cyc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_rise", 32'(busy_s), 32'd1);
    chk("error_clear", 32'(err_s), 32'd0);
  endtask

  task automatic feed(input int first, input int last, input int gap, input bit mid_start);
    for (int k = first; k < last; k++) begin
      bit got = 1'b0;
      for (int t = 0; t < gap; t++) begin @(posedge clk); #1; end
      in_pixel  = pix_q[k];
      in_weight = wt_q[k];
      in_valid  = 1'b1;
      for (int t = 0; t < 80 && !got; t++) begin
        @(negedge clk);
        got = rdy_s;
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("pair_accept", 32'(got), 32'd1);
      if (mid_start && k == 1) begin
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
  endtask

  task automatic finish_job(input int taps, input int rr_hold, input bit check_lat,
                            output logic [31:0] r);
    bit got = 1'b0;
    logic [31:0] exp = ref_result(taps);
    r = '0;
    for (int t = 0; t < 400 && !got; t++) begin
      @(negedge clk);
      got = rv_s;
      if (!got) begin @(posedge clk); #1; end
    end
    chk("result_valid_seen", 32'(got), 32'd1);
    r = res_s;
    chk("result", r, exp);
    if (check_lat) chk("latency", 32'(cyc - cyc_base), 32'(6 + 16 * taps));
    for (int t = 0; t < rr_hold; t++) begin
      @(posedge clk); #1;
      chk("rv_hold", 32'(rv_s), 32'd1);
      chk("result_stable", res_s, r);
    end
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    chk("rv_drop", 32'(rv_s), 32'd0);
    chk("busy_drop", 32'(busy_s), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_op"},    32'(op_v[sel]),  32'd0);
    chk({tag, "_index"}, 32'(idx_v[sel]), 32'd0);
    chk({tag, "_va"},    32'(a_v[sel]),   32'd0);
    chk({tag, "_vb"},    32'(b_v[sel]),   32'd0);
    chk({tag, "_rdy"},   32'(rdy_s),      32'd0);
    chk({tag, "_res"},   res_s,           32'd0);
    chk({tag, "_rv"},    32'(rv_s),       32'd0);
    chk({tag, "_busy"},  32'(busy_s),     32'd0);
    chk({tag, "_err"},   32'(err_s),      32'd0);
  endtask

  initial begin
    logic [31:0] r;
    int hs0, macs0, viol0, rvs0, gap;
    bit idle;

    repeat (3) @(posedge clk); #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // TAPS=1 job
    sel = 1'b0;
    pix_q = '{8'd10, 8'd20, 8'd30, 8'd40};
    wt_q  = '{8'd1, 8'd1, 8'd1, 8'd1};
    start_job();
    feed(0, 4, 0, 1'b0);
    finish_job(1, 0, 1'b1, r);
    chk("taps1_const", r, 32'h281E140A);

    // TAPS=2 job with negative weights
    sel = 1'b1;
    pix_q = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd5, 8'd5, 8'd0, 8'd1};
    wt_q  = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'hFF, 8'd7, 8'hD8};
    start_job();
    feed(0, 8, 0, 1'b0);
    finish_job(2, 0, 1'b1, r);
    chk("taps2_const", r, 32'h001E0F14);

    // Same pairs with 3-cycle in_valid gaps
    hs0 = hs; macs0 = macs; viol0 = viol;
    start_job();
    feed(0, 8, 3, 1'b0);
    finish_job(2, 0, 1'b0, r);
    chk("gap_handshakes", 32'(hs - hs0), 32'd8);
    chk("gap_macs", 32'(macs - macs0), 32'd8);
    chk("in_ready_outside_fetch", 32'(viol - viol0), 32'd0);

    // GET never completes: abort, then recover
    hang = 1'b1;
    fill_rand(8);
    rvs0 = rvs;
    start_job();
    feed(0, 8, 1, 1'b0);
    idle = 1'b0;
    for (int t = 0; t < 100 && !idle; t++) begin
      @(negedge clk);
      idle = !busy_s;
    end
    @(posedge clk); #1;
    chk("abort_busy", 32'(busy_s), 32'd0);
    chk("abort_error", 32'(err_s), 32'd1);
    chk("abort_no_result_valid", 32'(rvs - rvs0), 32'd0);
    hang = 1'b0;
    fill_rand(8);
    start_job();
    feed(0, 8, 0, 1'b0);
    finish_job(2, 0, 1'b1, r);

    // Asynchronous reset after 5 pairs, then a fresh job must re-clear the lanes
    fill_rand(8);
    start_job();
    feed(0, 5, 0, 1'b0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midjob_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    fill_rand(8);
    start_job();
    feed(0, 8, 0, 1'b0);
    finish_job(2, 0, 1'b1, r);

    // start during MAC_WAIT is dropped; result held while result_ready is low
    fill_rand(8);
    start_job();
    feed(0, 8, 2, 1'b1);
    finish_job(2, 10, 1'b0, r);
    repeat (5) @(posedge clk); #1;
    chk("start_not_queued", 32'(busy_s), 32'd0);

    // Random jobs on both sequencers
    for (int j = 0; j < 4; j++) begin
      sel = 1'(j);
      gap = int'($urandom_range(0, 2));
      fill_rand(4 * (j % 2 + 1));
      start_job();
      feed(0, 4 * (j % 2 + 1), gap, 1'b0);
      finish_job(j % 2 + 1, int'($urandom_range(0, 3)), gap == 0, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
